// File: rtl/lcd_result_formatter.sv
// Formats a signed 16-bit result as an LCD byte stream: cursor command, sign, five ASCII digits.
// Optional feature macro: LCD_FMT_ZERO_BLANK_EN (leading zeros among digits 10^4..10^1 sent as spaces).
module lcd_result_formatter #(
    parameter logic [7:0] CURSOR_CMD = 8'hC0,
    parameter logic [7:0] PLUS_CHAR  = 8'h2B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_is_cmd,
    input  logic        out_ready
);

    localparam int unsigned VAL_W  = 16;
    localparam int unsigned BCD_W  = 20;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned BYTES  = 7;
    localparam logic [2:0]  LAST_IDX  = 3'(BYTES - 1);
    localparam logic [3:0]  LAST_STEP = 4'(VAL_W - 1);
    localparam logic [7:0]  MINUS_CHAR = 8'h2D;
    localparam logic [7:0]  ZERO_CHAR  = 8'h30;

    typedef enum logic [1:0] {IDLE, CONVERT, SEND, FINISH} state_t;

    state_t             state, state_d;
    logic [3:0]         cnt, cnt_d;
    logic [BCD_W-1:0]   bcd, bcd_d;
    logic [VAL_W-1:0]   mag, mag_d;
    logic               sign, sign_d;
    logic [2:0]         idx, idx_d, next_idx;
    logic [7:0]         data_d;
    logic               valid_d, is_cmd_d, busy_d, done_d;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Returns {is_cmd, byte} for a given position in the 7-byte sequence.
    function automatic logic [8:0] byte_for(input logic [2:0] i, input logic [BCD_W-1:0] b,
                                            input logic s);
        logic [3:0] d;
        logic       blank;
        blank = 1'b0;
        case (i)
            3'd2:    d = b[19:16];
            3'd3:    d = b[15:12];
            3'd4:    d = b[11:8];
            3'd5:    d = b[7:4];
            default: d = b[3:0];
        endcase
`ifdef LCD_FMT_ZERO_BLANK_EN
        case (i)
            3'd2:    blank = (b[19:16] == 4'd0);
            3'd3:    blank = (b[19:12] == 8'd0);
            3'd4:    blank = (b[19:8] == 12'd0);
            3'd5:    blank = (b[19:4] == 16'd0);
            default: blank = 1'b0;
        endcase
`endif
        case (i)
            3'd0:    return {1'b1, CURSOR_CMD};
            3'd1:    return {1'b0, (s ? MINUS_CHAR : PLUS_CHAR)};
            default: return {1'b0, (blank ? 8'h20 : ZERO_CHAR + 8'(d))};
        endcase
    endfunction

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        bcd_d    = bcd;
        mag_d    = mag;
        sign_d   = sign;
        idx_d    = idx;
        data_d   = out_data;
        valid_d  = out_valid;
        is_cmd_d = out_is_cmd;
        done_d   = 1'b0;
        next_idx = idx + 3'd1;

        case (state)
            IDLE: begin
                if (start) begin
                    sign_d  = value[15];
                    mag_d   = value[15] ? 16'(~value + 16'd1) : value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, mag_d} = {dabble_adjust(bcd), mag} << 1;
                cnt_d = cnt + 4'd1;
                if (cnt == LAST_STEP) begin
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // First SEND cycle only loads byte 0; later cycles advance on accepted transfers.
                if (!out_valid) begin
                    valid_d              = 1'b1;
                    {is_cmd_d, data_d}   = byte_for(idx, bcd, sign);
                end else if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        valid_d  = 1'b0;
                        is_cmd_d = 1'b0;
                        idx_d    = '0;
                        state_d  = FINISH;
                    end else begin
                        idx_d              = next_idx;
                        {is_cmd_d, data_d} = byte_for(next_idx, bcd, sign);
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bcd        <= '0;
            mag        <= '0;
            sign       <= 1'b0;
            idx        <= '0;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            out_is_cmd <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bcd        <= bcd_d;
            mag        <= mag_d;
            sign       <= sign_d;
            idx        <= idx_d;
            out_data   <= data_d;
            out_valid  <= valid_d;
            out_is_cmd <= is_cmd_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule
